// File: rtl/dog_filter_stream_if.sv
// rtl/dog_filter_stream_if.sv - pixel-in / filtered-result-out handshake bundle
// The master side drives pixels and out_ready; the slave side is the filter.
interface dog_filter_stream_if #(
  parameter int PIX_W = 8
);
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W+1:0] out_data;
  logic             out_eof;

  modport master (
    output mode, in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_data, out_eof
  );

  modport slave (
    input  mode, in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_data, out_eof
  );
endinterface

// File: rtl/dog_filter_stream.sv
// rtl/dog_filter_stream.sv - streaming 5x5 difference-of-Gaussians filter
// Four line buffers feed a 5x5 window; three stall-coupled stages produce DoG/GA/GB/centre.
module dog_filter_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic               clk,
  input  logic               rst,
  dog_filter_stream_if.slave bus
);
  localparam int ACC_W = PIX_W + 8;
  localparam int OUT_W = PIX_W + 2;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);

  function automatic logic [3:0] ka(input int i);
    case (i)
      0, 4:    ka = 4'd1;
      1, 3:    ka = 4'd4;
      default: ka = 4'd6;
    endcase
  endfunction

  function automatic logic [3:0] kb(input int i);
    kb = (i == 0 || i == 4) ? 4'd1 : 4'd2;
  endfunction

  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [1:0]       r_mode;
  logic [PIX_W-1:0] r_lb [4][IMG_W];
  logic [PIX_W-1:0] r_win [5][5];
  logic             r_v1, r_v2, r_v3;
  logic             r_eof1, r_eof2, r_eof3;
  logic [1:0]       r_m1, r_m2;
  logic [ACC_W-1:0] r_ha [5];
  logic [ACC_W-1:0] r_hb [5];
  logic [PIX_W-1:0] r_cen2;
  logic [OUT_W-1:0] r_data;

  logic             w_en, w_fire, w_first, w_x_last, w_y_last;
  logic [1:0]       w_frame_mode;
  logic [PIX_W-1:0] w_col [5];
  logic [ACC_W-1:0] w_ha [5];
  logic [ACC_W-1:0] w_hb [5];
  logic [ACC_W-1:0] w_sa, w_sb;
  logic [OUT_W-1:0] w_ga, w_gb, w_result;

  assign w_en         = !r_v3 || bus.out_ready;
  assign w_fire       = bus.in_valid && w_en;
  assign w_first      = (r_x == '0) && (r_y == '0);
  assign w_x_last     = (r_x == XW'(IMG_W - 1));
  assign w_y_last     = (r_y == YW'(IMG_H - 1));
  assign w_frame_mode = w_first ? bus.mode : r_mode;

  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_v3;
  assign bus.out_data  = r_data;
  assign bus.out_eof   = r_eof3;

  // Column slice, oldest line on top: row 0 is y-4, row 4 is the incoming pixel.
  always_comb begin
    w_col[0] = r_lb[3][r_x];
    w_col[1] = r_lb[2][r_x];
    w_col[2] = r_lb[1][r_x];
    w_col[3] = r_lb[0][r_x];
    w_col[4] = bus.in_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_mode <= 2'd0;
    end else if (w_fire) begin
      if (w_first) r_mode <= bus.mode;
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_lb[0][r_x] <= bus.in_pix;
      for (int k = 1; k < 4; k++) r_lb[k][r_x] <= r_lb[k-1][r_x];
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) r_win[r][c] <= r_win[r][c+1];
        r_win[r][4] <= w_col[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      w_ha[r] = '0;
      w_hb[r] = '0;
      for (int c = 0; c < 5; c++) begin
        w_ha[r] = w_ha[r] + ACC_W'(ka(c)) * ACC_W'(r_win[r][c]);
        w_hb[r] = w_hb[r] + ACC_W'(kb(c)) * ACC_W'(r_win[r][c]);
      end
    end
  end

  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int r = 0; r < 5; r++) begin
      w_sa = w_sa + ACC_W'(ka(r)) * r_ha[r];
      w_sb = w_sb + ACC_W'(kb(r)) * r_hb[r];
    end
    w_ga = OUT_W'(w_sa >> 8);
    w_gb = OUT_W'(w_sb >> 6);
    case (r_m2)
      2'd0:    w_result = w_ga - w_gb;
      2'd1:    w_result = w_ga;
      2'd2:    w_result = w_gb;
      default: w_result = OUT_W'(r_cen2);
    endcase
  end

  // Mode travels with each window so a new frame's mode cannot retag the previous frame's tail.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_eof1 <= w_x_last && w_y_last;
      r_m1   <= w_frame_mode;
      r_eof2 <= r_eof1;
      r_m2   <= r_m1;
      r_ha   <= w_ha;
      r_hb   <= w_hb;
      r_cen2 <= r_win[2][2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_eof3 <= 1'b0;
      r_data <= '0;
    end else if (w_en) begin
      r_v1   <= w_fire && (r_x >= XW'(4)) && (r_y >= YW'(4));
      r_v2   <= r_v1;
      r_v3   <= r_v2;
      r_eof3 <= r_v2 && r_eof2;
      if (r_v2) r_data <= w_result;
    end
  end
endmodule

// File: tb/tb_dog_filter_stream.sv
// tb/tb_dog_filter_stream.sv - scoreboard bench for dog_filter_stream on 8x8, 5x5 and 6x6 frames
module tb_dog_filter_stream;
  typedef struct packed {
    logic [9:0] data;
    logic       eof;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  int         sel;
  logic       d_valid;
  logic [7:0] d_pix;
  logic [1:0] d_mode;
  logic       d_ready;
  logic       rand_ready;

  always #5 clk = ~clk;

  dog_filter_stream_if #(.PIX_W(8)) bus8 ();
  dog_filter_stream_if #(.PIX_W(8)) bus5 ();
  dog_filter_stream_if #(.PIX_W(8)) bus6 ();

  dog_filter_stream #(.PIX_W(8), .IMG_W(8), .IMG_H(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  dog_filter_stream #(.PIX_W(8), .IMG_W(5), .IMG_H(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));
  dog_filter_stream #(.PIX_W(8), .IMG_W(6), .IMG_H(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  assign bus8.in_valid = d_valid && (sel == 0);
  assign bus5.in_valid = d_valid && (sel == 1);
  assign bus6.in_valid = d_valid && (sel == 2);
  assign bus8.in_pix = d_pix;
  assign bus5.in_pix = d_pix;
  assign bus6.in_pix = d_pix;
  assign bus8.mode = d_mode;
  assign bus5.mode = d_mode;
  assign bus6.mode = d_mode;
  assign bus8.out_ready = d_ready;
  assign bus5.out_ready = d_ready;
  assign bus6.out_ready = d_ready;

  logic       ov [3];
  logic       oe [3];
  logic       ir [3];
  logic [9:0] od [3];
  assign ov[0] = bus8.out_valid;
  assign ov[1] = bus5.out_valid;
  assign ov[2] = bus6.out_valid;
  assign oe[0] = bus8.out_eof;
  assign oe[1] = bus5.out_eof;
  assign oe[2] = bus6.out_eof;
  assign ir[0] = bus8.in_ready;
  assign ir[1] = bus5.in_ready;
  assign ir[2] = bus6.in_ready;
  assign od[0] = bus8.out_data;
  assign od[1] = bus5.out_data;
  assign od[2] = bus6.out_data;

  exp_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         n_out;
  int         first_cyc;
  int         last_cyc;
  int         cyc = 0;
  logic [7:0] img [8][8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Back-pressure source: changes away from both the sampling and the driving instants.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      d_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output transfer, checks stall behaviour.
  initial begin
    logic       prev_stall [3];
    logic [9:0] prev_d [3];
    logic       prev_e [3];
    exp_t       e;
    for (int i = 0; i < 3; i++) prev_stall[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          prev_stall[i] = 1'b0;
        end else begin
          if (prev_stall[i]) begin
            check("stall_out_valid", 32'(ov[i]), 32'd1);
            check("stall_out_data", 32'(od[i]), 32'(prev_d[i]));
            check("stall_out_eof", 32'(oe[i]), 32'(prev_e[i]));
          end
          if (ov[i] && !d_ready) check("stall_in_ready", 32'(ir[i]), 32'd0);
          if (ov[i] && d_ready) begin
            if (n_out == 0) first_cyc = cyc;
            n_out++;
            if (q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_output: dut %0d gave %0h, required no output", i, od[i]);
            end else begin
              e = q.pop_front();
              check("out_data", 32'(od[i]), 32'(e.data));
              check("out_eof", 32'(oe[i]), 32'(e.eof));
            end
          end
          prev_stall[i] = ov[i] && !d_ready;
          prev_d[i] = od[i];
          prev_e[i] = oe[i];
        end
      end
    end
  end

  task automatic send(input logic [7:0] p, input logic [1:0] m, input int gap);
    bit ok = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      d_valid = 1'b0;
    end
    @(negedge clk);
    d_valid = 1'b1;
    d_pix = p;
    d_mode = m;
    for (int t = 0; t < 1000 && !ok; t++) begin
      #1;
      if (ir[sel]) begin
        last_cyc = cyc;
        ok = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: in_ready stayed 0, required 1 within 1000 cycles");
    end
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    d_valid = 1'b0;
    while (q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d outputs outstanding, required 0", q.size());
      q.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic push(input logic [9:0] d, input logic eof);
    exp_t e;
    e.data = d;
    e.eof = eof;
    q.push_back(e);
  endtask

  // Sends img[0..h-1][0..w-1]; mode switches to m_alt from pixel alt_at on (ignored mid-frame).
  task automatic send_img(input int w, input int h, input logic [1:0] m, input logic [1:0] m_alt,
                          input int alt_at, input bit gaps);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        send(img[y][x], (y * w + x >= alt_at) ? m_alt : m,
             gaps ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0) : 0);
  endtask

  function automatic logic [9:0] model(input int cx, input int cy, input logic [1:0] m);
    int a[5];
    int b[5];
    int sa = 0;
    int sb = 0;
    int ga, gb;
    a = '{1, 4, 6, 4, 1};
    b = '{1, 2, 2, 2, 1};
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        sa += a[r] * a[c] * int'(img[cy-2+r][cx-2+c]);
        sb += b[r] * b[c] * int'(img[cy-2+r][cx-2+c]);
      end
    ga = sa / 256;
    gb = sb / 64;
    case (m)
      2'd0:    model = 10'(ga - gb);
      2'd1:    model = 10'(ga);
      2'd2:    model = 10'(gb);
      default: model = {2'b00, img[cy][cx]};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] imp_exp [4];
    logic [9:0] quad_exp [3][2];
    logic [1:0] quad_mode [3];
    int t44;

    imp_exp = '{10'd20, 10'd35, 10'd15, 10'd255};
    quad_exp = '{'{10'd20, 10'd40}, '{10'd22, 10'd42}, '{10'h3FE, 10'h3FE}};
    quad_mode = '{2'd1, 2'd2, 2'd0};
    rst = 1'b1;
    sel = 0;
    d_valid = 1'b0;
    d_pix = 8'd0;
    d_mode = 2'd0;
    d_ready = 1'b1;
    rand_ready = 1'b0;
    n_out = 0;
    t44 = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_out_valid", 32'(ov[i]), 32'd0);
      check("reset_out_eof", 32'(oe[i]), 32'd0);
      check("reset_out_data", 32'(od[i]), 32'd0);
      check("reset_in_ready", 32'(ir[i]), 32'd1);
    end
    rst = 1'b0;

    // Constant 100, DoG: 16 zeros, eof on the last, latency 3 from pixel (4,4).
    sel = 0;
    n_out = 0;
    for (int i = 0; i < 16; i++) push(10'd0, i == 15);
    for (int i = 0; i < 64; i++) begin
      send(8'd100, 2'd0, 0);
      if (i == 4 * 8 + 4) t44 = last_cyc;
    end
    drain();
    check("const_count", 32'(n_out), 32'd16);
    check("first_latency", 32'(first_cyc - t44), 32'd3);

    // 5x5 impulse at the centre, four back-to-back frames in modes 0..3.
    sel = 1;
    n_out = 0;
    for (int m = 0; m < 4; m++) push(imp_exp[m], 1'b1);
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 25; i++) send((i == 12) ? 8'd255 : 8'd0, 2'(m), 0);
    drain();
    check("impulse_count", 32'(n_out), 32'd4);

    // Horizontal ramp: centre and GA both give x-2.
    sel = 0;
    n_out = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) img[y][x] = 8'(x);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) push(10'(2 + i % 4), i == 15);
    send_img(8, 8, 2'd3, 2'd3, 64, 1'b0);
    send_img(8, 8, 2'd1, 2'd1, 64, 1'b0);
    drain();
    check("ramp_count", 32'(n_out), 32'd32);

    // Random pixels with input gaps and 50% back-pressure against the reference model.
    sel = 0;
    n_out = 0;
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) img[y][x] = 8'($urandom_range(0, 255));
      for (int cy = 2; cy < 6; cy++)
        for (int cx = 2; cx < 6; cx++) push(model(cx, cy, 2'(f)), cx == 5 && cy == 5);
      send_img(8, 8, 2'(f), 2'(f + 1), 30, 1'b1);
    end
    drain();
    rand_ready = 1'b0;
    check("random_count", 32'(n_out), 32'd48);

    // Abort a frame after 20 pixels with a 1-cycle reset, then a clean frame of 50.
    sel = 0;
    n_out = 0;
    for (int i = 0; i < 20; i++) send(8'd200, 2'd1, 0);
    @(negedge clk);
    d_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) push(10'd0, i == 15);
    for (int i = 0; i < 64; i++) send(8'd50, 2'd0, 0);
    drain();
    check("reset_abort_count", 32'(n_out), 32'd16);

    // 6x6 quadratic 4*x^2: GA=4X^2+4, GB=4X^2+6, DoG=-2; mode flips mid-frame are ignored.
    sel = 2;
    n_out = 0;
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 6; x++) img[y][x] = 8'(4 * x * x);
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 4; i++) push(quad_exp[f][i % 2], i == 3);
    for (int f = 0; f < 3; f++)
      send_img(6, 6, quad_mode[f], quad_mode[f] ^ 2'd3, 15, 1'b0);
    drain();
    check("b2b_count", 32'(n_out), 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
